// File: rtl/operand_loader.sv
// Assembles a 15-byte frame (9 image, 5 weight, 1 bias) into one MAC operand set; out_valid the cycle after the last byte.
// in_ready drops while the set is presented, so no frame overlaps; `WEIGHT_REUSE_EN adds reuse_w for 9-byte image-only frames.
module operand_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [71:0] image_out,
  output logic [35:0] weight_out,
  output logic [4:0]  exp_bias_out,
  output logic        out_valid,
  input  logic        out_ready
`ifdef WEIGHT_REUSE_EN
  ,
  input  logic        reuse_w
`endif
);

  typedef enum logic [1:0] {LOAD_IMG, LOAD_WGT, LOAD_BIAS, PRESENT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [71:0] image_q, image_d;
  logic [35:0] weight_q, weight_d;
  logic [4:0]  bias_q, bias_d;
  logic        accept;
  logic        skip_wgt;

  // A flushed cycle never accepts its byte.
  assign accept = in_valid && in_ready && !flush;

`ifdef WEIGHT_REUSE_EN
  logic reuse_q, reuse_d;

  always_comb begin
    reuse_d = reuse_q;
    if (accept && state_q == LOAD_IMG && cnt_q == 4'd0) reuse_d = reuse_w;
  end

  always_ff @(posedge clk) begin
    if (rst) reuse_q <= 1'b0;
    else     reuse_q <= reuse_d;
  end

  assign skip_wgt = reuse_q;
`else
  assign skip_wgt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD_IMG;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_IMG: begin
        if (accept && cnt_q == 4'd8) state_d = skip_wgt ? PRESENT : LOAD_WGT;
      end
      LOAD_WGT: begin
        if (flush)                         state_d = LOAD_IMG;
        else if (accept && cnt_q == 4'd13) state_d = LOAD_BIAS;
      end
      LOAD_BIAS: begin
        if (flush)       state_d = LOAD_IMG;
        else if (accept) state_d = PRESENT;
      end
      PRESENT: begin
        if (out_ready) state_d = LOAD_IMG;
      end
      default: state_d = LOAD_IMG;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != PRESENT);
    out_valid = (state_q == PRESENT);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush && state_q != PRESENT)      cnt_d = 4'd0;
    else if (accept)                      cnt_d = (state_d == PRESENT) ? 4'd0 : cnt_q + 4'd1;
    else if (state_q == PRESENT && out_ready) cnt_d = 4'd0;
  end

  // Each field is written only on the cycle its byte is accepted.
  always_comb begin
    image_d  = image_q;
    weight_d = weight_q;
    bias_d   = bias_q;
    if (accept && state_q == LOAD_IMG) begin
      for (int k = 0; k < 9; k++) begin
        if (cnt_q == 4'(k)) image_d[8*k +: 8] = in_data;
      end
    end
    if (accept && state_q == LOAD_WGT) begin
      for (int j = 0; j < 4; j++) begin
        if (cnt_q == 4'(9 + j)) weight_d[8*j +: 8] = in_data;
      end
      if (cnt_q == 4'd13) weight_d[35:32] = in_data[3:0];
    end
    if (accept && state_q == LOAD_BIAS) bias_d = in_data[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 4'd0;
      image_q  <= '0;
      weight_q <= '0;
      bias_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      image_q  <= image_d;
      weight_q <= weight_d;
      bias_q   <= bias_d;
    end
  end

  assign image_out    = image_q;
  assign weight_out   = weight_q;
  assign exp_bias_out = bias_q;

endmodule
